// File: rtl/pattern_gen_pkg.sv
// Shared types and elaboration helpers for the test-pattern generator.
package pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_RAMP  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  // Total period of a line or frame: active + front + sync + back.
  function automatic int period(input int act, input int front, input int sync, input int back);
    return act + front + sync + back;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pattern_gen_if.sv
// Control inputs and video outputs of the pattern generator, grouped as one bundle.
interface pattern_gen_if import pattern_pkg::*; #(parameter int BPC = 8);
  mode_e            MODE;
  logic             SCROLL_EN;
  logic [3*BPC-1:0] SOLID_RGB;
  logic [BPC-1:0]   VGA_R;
  logic [BPC-1:0]   VGA_G;
  logic [BPC-1:0]   VGA_B;
  logic             VGA_HS;
  logic             VGA_VS;
  logic             VGA_DE;
  logic             FRAME_START;

  modport master (
    input  MODE, SCROLL_EN, SOLID_RGB,
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, FRAME_START
  );

  modport slave (
    output MODE, SCROLL_EN, SOLID_RGB,
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, FRAME_START
  );
endinterface

// File: rtl/pattern_gen_timing.sv
// Raster timing: h/v counters plus combinational decode of active, sync windows and strobes.
module pattern_timing import pattern_pkg::*; #(
  parameter int HACTIVE = 640,
  parameter int HFRONT  = 16,
  parameter int HSYNC   = 96,
  parameter int HBACK   = 48,
  parameter int VACTIVE = 480,
  parameter int VFRONT  = 10,
  parameter int VSYNC   = 2,
  parameter int VBACK   = 33
) (
  input  logic CLK,
  input  logic RST,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic frame,
  output logic line_start,
  output logic line_end,
  output logic frame_end
);

  localparam int HTOT = period(HACTIVE, HFRONT, HSYNC, HBACK);
  localparam int VTOT = period(VACTIVE, VFRONT, VSYNC, VBACK);
  localparam int HW   = cnt_w(HTOT);
  localparam int VW   = cnt_w(VTOT);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= frame_end ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // int casts keep the window bounds safe when a total is a power of two
  always_comb begin
    line_start = (hcnt == '0);
    line_end   = (int'(hcnt) == HTOT - 1);
    frame_end  = line_end && (int'(vcnt) == VTOT - 1);
    frame      = line_start && (vcnt == '0);
    active     = (int'(hcnt) < HACTIVE) && (int'(vcnt) < VACTIVE);
    hsync      = (int'(hcnt) >= HACTIVE + HFRONT) && (int'(hcnt) < HACTIVE + HFRONT + HSYNC);
    vsync      = (int'(vcnt) >= VACTIVE + VFRONT) && (int'(vcnt) < VACTIVE + VFRONT + VSYNC);
  end

endmodule

// File: rtl/pattern_gen.sv
// Test-pattern generator: scroll offset, incremental pattern counters and the output register.
module pattern_gen import pattern_pkg::*; #(
  parameter int HACTIVE  = 640,
  parameter int HFRONT   = 16,
  parameter int HSYNC    = 96,
  parameter int HBACK    = 48,
  parameter int VACTIVE  = 480,
  parameter int VFRONT   = 10,
  parameter int VSYNC    = 2,
  parameter int VBACK    = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int BPC      = 8,
  parameter int NBARS    = 8,
  parameter int BAND_H   = 120,
  parameter int CELL     = 32
) (
  input  logic         CLK,
  input  logic         RST,
  pattern_gen_if.master bus
);

  localparam int BAR_W = HACTIVE / NBARS;
  localparam int XW    = cnt_w(HACTIVE);
  localparam int BIW   = cnt_w(NBARS);
  localparam int BPW   = cnt_w(BAR_W);
  localparam int CW    = cnt_w(CELL);
  localparam int BHW   = cnt_w(BAND_H);

  // Horizontal pattern position for one x' value; the scroll offset uses the same form.
  typedef struct packed {
    logic [XW-1:0]  xp;
    logic [BIW-1:0] bar_idx;
    logic [BPW-1:0] bar_px;
    logic [CW-1:0]  cell_px;
    logic           cell_f;
    logic [BPC-1:0] ramp;
  } hpos_t;

  function automatic hpos_t hpos_inc(input hpos_t h);
    hpos_t n;
    n = '0;
    if (int'(h.xp) != HACTIVE - 1) begin
      n.xp      = h.xp + 1'b1;
      n.ramp    = h.ramp + 1'b1;
      n.bar_idx = h.bar_idx;
      n.bar_px  = h.bar_px + 1'b1;
      if (int'(h.bar_px) == BAR_W - 1) begin
        n.bar_px  = '0;
        n.bar_idx = h.bar_idx + 1'b1;
      end
      n.cell_f  = h.cell_f;
      n.cell_px = h.cell_px + 1'b1;
      if (int'(h.cell_px) == CELL - 1) begin
        n.cell_px = '0;
        n.cell_f  = ~h.cell_f;
      end
    end
    return n;
  endfunction

  logic active, hsync, vsync, frame, line_start, line_end, frame_end;

  pattern_timing #(
    .HACTIVE(HACTIVE), .HFRONT(HFRONT), .HSYNC(HSYNC), .HBACK(HBACK),
    .VACTIVE(VACTIVE), .VFRONT(VFRONT), .VSYNC(VSYNC), .VBACK(VBACK)
  ) u_timing (
    .CLK(CLK), .RST(RST),
    .active(active), .hsync(hsync), .vsync(vsync), .frame(frame),
    .line_start(line_start), .line_end(line_end), .frame_end(frame_end)
  );

  hpos_t            off, off_cur, pos, pos_cur;
  mode_e            mode_q, mode_cur;
  logic [3*BPC-1:0] solid_q, solid_cur, rgb;
  logic [BHW-1:0]   band_cnt;
  logic             band_f;
  logic [CW-1:0]    vcell_cnt;
  logic             vcell_f;
  logic [2:0]       bar_c;

  // On the boundary cycle the freshly latched values already drive pixel (0,0).
  always_comb begin
    off_cur   = (frame && bus.SCROLL_EN) ? hpos_inc(off) : off;
    pos_cur   = line_start ? off_cur : pos;
    mode_cur  = frame ? bus.MODE : mode_q;
    solid_cur = frame ? bus.SOLID_RGB : solid_q;
  end

  always_comb begin
    bar_c = band_f ? 3'(int'(pos_cur.bar_idx))
                   : 3'(NBARS - 1 - int'(pos_cur.bar_idx));
    rgb = '0;
    case (mode_cur)
      MODE_BARS:  rgb = {{BPC{bar_c[2]}}, {BPC{bar_c[1]}}, {BPC{bar_c[0]}}};
      MODE_CHECK: rgb = (pos_cur.cell_f ^ vcell_f) ? '0 : '1;
      MODE_RAMP:  rgb = {3{pos_cur.ramp}};
      MODE_SOLID: rgb = solid_cur;
      default:    rgb = '0;
    endcase
    if (!active) rgb = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      off             <= '0;
      pos             <= '0;
      mode_q          <= MODE_BARS;
      solid_q         <= '0;
      band_cnt        <= '0;
      band_f          <= 1'b0;
      vcell_cnt       <= '0;
      vcell_f         <= 1'b0;
      bus.VGA_R       <= '0;
      bus.VGA_G       <= '0;
      bus.VGA_B       <= '0;
      bus.VGA_DE      <= 1'b0;
      bus.VGA_HS      <= ~SYNC_POL;
      bus.VGA_VS      <= ~SYNC_POL;
      bus.FRAME_START <= 1'b0;
    end else begin
      off <= off_cur;
      pos <= hpos_inc(pos_cur);
      if (frame) begin
        mode_q  <= bus.MODE;
        solid_q <= bus.SOLID_RGB;
      end
      // vertical band/cell state steps per line and restarts with each frame
      if (frame_end) begin
        band_cnt  <= '0;
        band_f    <= 1'b0;
        vcell_cnt <= '0;
        vcell_f   <= 1'b0;
      end else if (line_end) begin
        if (int'(band_cnt) == BAND_H - 1) begin
          band_cnt <= '0;
          band_f   <= ~band_f;
        end else begin
          band_cnt <= band_cnt + 1'b1;
        end
        if (int'(vcell_cnt) == CELL - 1) begin
          vcell_cnt <= '0;
          vcell_f   <= ~vcell_f;
        end else begin
          vcell_cnt <= vcell_cnt + 1'b1;
        end
      end
      bus.VGA_R       <= rgb[3*BPC-1:2*BPC];
      bus.VGA_G       <= rgb[2*BPC-1:BPC];
      bus.VGA_B       <= rgb[BPC-1:0];
      bus.VGA_DE      <= active;
      bus.VGA_HS      <= hsync ? SYNC_POL : ~SYNC_POL;
      bus.VGA_VS      <= vsync ? SYNC_POL : ~SYNC_POL;
      bus.FRAME_START <= frame;
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen on a shrunken raster with an arithmetic reference model.
module tb_pattern_gen;
  import pattern_pkg::*;

  localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 12, VF = 1, VSW = 2, VB = 1;
  localparam int BPC = 3, NB = 8, BH = 4, CL = 4;
  localparam bit SP = 1'b0;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FR = HT * VT;
  localparam int BW = HA / NB;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  pattern_gen_if #(.BPC(BPC)) bus();

  pattern_gen #(
    .HACTIVE(HA), .HFRONT(HF), .HSYNC(HSW), .HBACK(HB),
    .VACTIVE(VA), .VFRONT(VF), .VSYNC(VSW), .VBACK(VB),
    .SYNC_POL(SP), .BPC(BPC), .NBARS(NB), .BAND_H(BH), .CELL(CL)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3*BPC-1:0] rgb;
    logic de, hs, vs, fs;
    int   h, v;
  } exp_t;

  exp_t q[$];
  exp_t e_push, e_pop;
  int checks = 0, errors = 0;

  // Model state: position the next active edge will process, plus frame-latched controls.
  int mh = 0, mv = 0, moff = 0, mmode = 0;
  logic [3*BPC-1:0] msolid = '0;

  function automatic logic [3*BPC-1:0] ref_rgb(input int mode, input int x, input int y,
                                               input logic [3*BPC-1:0] solid);
    logic [3*BPC-1:0] r;
    logic [BPC-1:0]   rv;
    int c;
    r = '0;
    case (mode)
      0: begin
        c = (((y / BH) % 2) == 0) ? (NB - 1 - x / BW) : (x / BW);
        r = {{BPC{c[2]}}, {BPC{c[1]}}, {BPC{c[0]}}};
      end
      1: r = ((((x / CL) ^ (y / CL)) & 1) == 0) ? {3*BPC{1'b1}} : '0;
      2: begin
        rv = BPC'(x % (1 << BPC));
        r  = {3{rv}};
      end
      default: r = solid;
    endcase
    return r;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      mh = 0; mv = 0; moff = 0; mmode = 0; msolid = '0;
      e_push.rgb = '0; e_push.de = 1'b0; e_push.hs = ~SP; e_push.vs = ~SP;
      e_push.fs = 1'b0; e_push.h = -1; e_push.v = -1;
    end else begin
      if (mh == 0 && mv == 0) begin
        mmode  = int'(bus.MODE);
        msolid = bus.SOLID_RGB;
        if (bus.SCROLL_EN) moff = (moff + 1) % HA;
      end
      e_push.de  = (mh < HA) && (mv < VA);
      e_push.rgb = e_push.de ? ref_rgb(mmode, (mh + moff) % HA, mv, msolid) : '0;
      e_push.hs  = (mh >= HA + HF && mh < HA + HF + HSW) ? SP : ~SP;
      e_push.vs  = (mv >= VA + VF && mv < VA + VF + VSW) ? SP : ~SP;
      e_push.fs  = (mh == 0 && mv == 0);
      e_push.h   = mh;
      e_push.v   = mv;
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv = (mv + 1) % VT;
      end
    end
    q.push_back(e_push);
  end

  logic [3*BPC+3:0] got, want;
  int  hs_run = 0, fs_gap = 0;
  bit  fs_seen = 0, de_armed = 1, de_prev = 0;

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      e_pop = q.pop_front();
      got  = {bus.VGA_R, bus.VGA_G, bus.VGA_B, bus.VGA_DE, bus.VGA_HS, bus.VGA_VS, bus.FRAME_START};
      want = {e_pop.rgb, e_pop.de, e_pop.hs, e_pop.vs, e_pop.fs};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pixel h=%0d v=%0d got rgb/de/hs/vs/fs=%h want %h", e_pop.h, e_pop.v, got, want);
      end
    end
    if (RST) begin
      hs_run = 0; fs_gap = 0; fs_seen = 0; de_armed = 1; de_prev = 0;
    end else begin
      if (bus.VGA_DE && !de_prev && de_armed) begin
        checks++;
        if (bus.FRAME_START !== 1'b1) begin
          errors++;
          $display("FAIL first_de_fs got FRAME_START=%b want 1", bus.FRAME_START);
        end
        de_armed = 0;
      end
      de_prev = bus.VGA_DE;
      if (bus.VGA_HS === SP) hs_run++;
      else if (hs_run > 0) begin
        checks++;
        if (hs_run != HSW) begin
          errors++;
          $display("FAIL hsync_width got %0d want %0d", hs_run, HSW);
        end
        hs_run = 0;
      end
      fs_gap++;
      if (bus.FRAME_START === 1'b1) begin
        if (fs_seen) begin
          checks++;
          if (fs_gap != FR) begin
            errors++;
            $display("FAIL frame_period got %0d want %0d", fs_gap, FR);
          end
        end
        fs_seen = 1;
        fs_gap  = 0;
      end
    end
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Park on the negedge just before the edge that processes raster position (h,v).
  task automatic wait_pos(input int h, input int v);
    int n;
    n = 0;
    while (!(mh == h && mv == v) && n < 2 * FR) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n >= 2 * FR) begin
      errors++;
      $display("FAIL wait_pos(%0d,%0d) timeout got h=%0d v=%0d", h, v, mh, mv);
    end
  endtask

  initial begin
    bus.MODE      = MODE_BARS;
    bus.SCROLL_EN = 1'b0;
    bus.SOLID_RGB = '0;
    RST = 1'b1;
    run_cycles(3);
    RST = 1'b0;
    run_cycles(FR);

    bus.MODE = MODE_CHECK;
    run_cycles(2 * FR);

    // bars latched exactly on the boundary, solid requested mid-frame
    wait_pos(0, 0);
    bus.MODE = MODE_BARS;
    wait_pos(0, 8);
    bus.MODE      = MODE_SOLID;
    bus.SOLID_RGB = (3*BPC)'($urandom);
    run_cycles(2 * FR);

    // scroll through a full offset wrap
    wait_pos(0, 0);
    bus.MODE      = MODE_RAMP;
    bus.SCROLL_EN = 1'b1;
    run_cycles((HA + 2) * FR);

    for (int i = 0; i < 8; i++) begin
      run_cycles($urandom_range(1, FR));
      bus.MODE      = mode_e'($urandom_range(0, 3));
      bus.SCROLL_EN = 1'($urandom_range(0, 1));
      bus.SOLID_RGB = (3*BPC)'($urandom);
    end
    run_cycles(FR);

    // mid-frame reset, then a clean frame with scrolling still requested
    wait_pos(5, 7);
    RST = 1'b1;
    run_cycles(2);
    RST = 1'b0;
    run_cycles(2 * FR + 10);

    run_cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
